// File: rtl/mem_stream_loader_pkg.sv
// Shared types and constants for the byte-stream RAM loader.
package mem_stream_loader_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_PACK  = 3'd1,
    ST_WRITE = 3'd2,
    ST_READ  = 3'd3,
    ST_DRAIN = 3'd4
  } state_t;

  localparam int unsigned RAM_DEPTH      = 1024;
  localparam int unsigned BYTES_PER_WORD = 4;

  // Byte-lane enables for a word holding k bytes, filled from lane 0 upward.
  function automatic logic [3:0] be_for_count(input logic [2:0] k);
    case (k)
      3'd1:    be_for_count = 4'h1;
      3'd2:    be_for_count = 4'h3;
      3'd3:    be_for_count = 4'h7;
      3'd4:    be_for_count = 4'hF;
      default: be_for_count = 4'h0;
    endcase
  endfunction

endpackage

// File: rtl/mem_stream_loader_byte_packer.sv
// Little-endian byte-to-word packer: holds the partial word and its fill count.
module mem_stream_loader_byte_packer
  import mem_stream_loader_pkg::*;
(
  input  logic        clk,
  input  logic        reset_n,
  input  logic        take,
  input  logic        first,
  input  logic        close,
  input  logic [7:0]  data,
  output logic [31:0] word_c,
  output logic [3:0]  be_c,
  output logic        full_c
);

  logic [31:0] lanes_q;
  logic [1:0]  cnt_q;
  logic [1:0]  lane;
  logic [2:0]  cnt_next;

  // Word as it would look with the presented byte merged into the next lane.
  always_comb begin
    lane     = first ? 2'd0 : cnt_q;
    word_c   = first ? 32'd0 : lanes_q;
    word_c[{lane, 3'b000} +: 8] = data;
    cnt_next = {1'b0, lane} + 3'd1;
    be_c     = be_for_count(cnt_next);
    full_c   = (cnt_next == 3'(BYTES_PER_WORD));
  end

  // Hold the partial word; a closing byte empties the packer for the next word.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      lanes_q <= '0;
      cnt_q   <= '0;
    end else if (take) begin
      if (close) begin
        lanes_q <= '0;
        cnt_q   <= '0;
      end else begin
        lanes_q <= word_c;
        cnt_q   <= cnt_next[1:0];
      end
    end
  end

endmodule

// File: rtl/mem_stream_loader.sv
// Byte-stream loader and readback checksummer for a single-port word RAM.
module mem_stream_loader
  import mem_stream_loader_pkg::*;
#(
  parameter int unsigned ADDR_W    = 10,
  parameter int unsigned BASE_ADDR = 0
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [7:0]        in_data,
  input  logic              in_valid,
  input  logic              in_last,
  output logic              in_ready,
  output logic [ADDR_W-1:0] mem_address,
  output logic [3:0]        mem_byteenable,
  output logic              mem_chipselect,
  output logic              mem_write,
  output logic [31:0]       mem_writedata,
  input  logic [31:0]       mem_readdata,
  input  logic              sum_start,
  input  logic [ADDR_W:0]   sum_len,
  output logic              busy,
  output logic              load_done,
  output logic [ADDR_W:0]   load_words,
  output logic              overflow,
  output logic [31:0]       checksum,
  output logic              sum_valid
);

  localparam logic [ADDR_W:0]   DEPTH = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0]   ONE   = {{ADDR_W{1'b0}}, 1'b1};
  localparam logic [ADDR_W-1:0] BASE  = ADDR_W'(BASE_ADDR);

  state_t state_q, state_d;

  logic              ready_q;
  logic              last_q;
  logic              rd_cap_q;
  logic [ADDR_W:0]   rd_cnt_q, len_q;
  logic [31:0]       acc_q;

  logic              start_c, accept_c, first_c, closing_c, wr_ovf_c;
  logic [ADDR_W:0]   wr_off_c, len_clamp_c;
  logic [31:0]       pk_word_c;
  logic [3:0]        pk_be_c;
  logic              pk_full_c;

  logic [ADDR_W-1:0] addr_d;
  logic [3:0]        be_d;
  logic              cs_d, wr_d, done_d, ovf_d, sv_d, last_d;
  logic [31:0]       wdata_d, chk_d, acc_d;
  logic [ADDR_W:0]   words_d, rd_cnt_d, len_d;

  // A byte offered together with sum_start in IDLE is refused in the same cycle,
  // so the source never sees a handshake for a byte the loader drops.
  assign start_c     = sum_start && (state_q == ST_IDLE);
  assign in_ready    = ready_q && !start_c;
  assign accept_c    = in_valid && in_ready;
  assign first_c     = (state_q == ST_IDLE);
  assign closing_c   = accept_c && (pk_full_c || in_last);
  assign wr_off_c    = first_c ? '0 : load_words;
  assign wr_ovf_c    = (wr_off_c == DEPTH);
  assign len_clamp_c = (sum_len > DEPTH) ? DEPTH : sum_len;

  mem_stream_loader_byte_packer u_packer (
    .clk     (clk),
    .reset_n (reset_n),
    .take    (accept_c),
    .first   (first_c),
    .close   (closing_c),
    .data    (in_data),
    .word_c  (pk_word_c),
    .be_c    (pk_be_c),
    .full_c  (pk_full_c)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (!reset_n) state_q <= ST_IDLE;
    else          state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (start_c)       state_d = (sum_len == '0) ? ST_IDLE : ST_READ;
        else if (accept_c) state_d = closing_c ? ST_WRITE : ST_PACK;
      end
      ST_PACK:  if (closing_c) state_d = ST_WRITE;
      ST_WRITE: state_d = last_q ? ST_IDLE : ST_PACK;
      ST_READ:  if (rd_cnt_q == len_q) state_d = ST_DRAIN;
      ST_DRAIN: state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Next values of the registered outputs and datapath counters.
  always_comb begin
    addr_d   = '0;
    be_d     = '0;
    cs_d     = 1'b0;
    wr_d     = 1'b0;
    wdata_d  = '0;
    done_d   = 1'b0;
    sv_d     = 1'b0;
    ovf_d    = overflow;
    words_d  = load_words;
    chk_d    = checksum;
    acc_d    = acc_q;
    rd_cnt_d = rd_cnt_q;
    len_d    = len_q;
    last_d   = last_q;
    case (state_q)
      ST_IDLE: begin
        if (start_c) begin
          acc_d = '0;
          len_d = len_clamp_c;
          if (sum_len == '0) begin
            chk_d = '0;
            sv_d  = 1'b1;
          end else begin
            cs_d     = 1'b1;
            be_d     = 4'hF;
            addr_d   = BASE;
            rd_cnt_d = ONE;
          end
        end else if (accept_c) begin
          words_d = '0;
          ovf_d   = 1'b0;
        end
      end
      ST_WRITE: begin
        if (mem_chipselect) words_d = load_words + ONE;
        done_d = last_q;
      end
      ST_READ: begin
        if (rd_cap_q) acc_d = acc_q + mem_readdata;
        if (rd_cnt_q != len_q) begin
          cs_d     = 1'b1;
          be_d     = 4'hF;
          addr_d   = BASE + rd_cnt_q[ADDR_W-1:0];
          rd_cnt_d = rd_cnt_q + ONE;
        end
      end
      ST_DRAIN: begin
        chk_d = acc_q + mem_readdata;
        sv_d  = 1'b1;
      end
      default: ;
    endcase
    // Closing byte: issue the word next cycle, or drop it once the RAM is full.
    if (closing_c) begin
      last_d = in_last;
      if (wr_ovf_c) begin
        ovf_d = 1'b1;
      end else begin
        cs_d    = 1'b1;
        wr_d    = 1'b1;
        be_d    = pk_be_c;
        wdata_d = pk_word_c;
        addr_d  = BASE + wr_off_c[ADDR_W-1:0];
      end
    end
  end

  // Output and datapath registers.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      ready_q        <= 1'b0;
      busy           <= 1'b0;
      mem_address    <= '0;
      mem_byteenable <= '0;
      mem_chipselect <= 1'b0;
      mem_write      <= 1'b0;
      mem_writedata  <= '0;
      load_done      <= 1'b0;
      load_words     <= '0;
      overflow       <= 1'b0;
      checksum       <= '0;
      sum_valid      <= 1'b0;
      last_q         <= 1'b0;
      rd_cap_q       <= 1'b0;
      rd_cnt_q       <= '0;
      len_q          <= '0;
      acc_q          <= '0;
    end else begin
      ready_q        <= (state_d == ST_IDLE) || (state_d == ST_PACK);
      busy           <= (state_d != ST_IDLE);
      mem_address    <= addr_d;
      mem_byteenable <= be_d;
      mem_chipselect <= cs_d;
      mem_write      <= wr_d;
      mem_writedata  <= wdata_d;
      load_done      <= done_d;
      load_words     <= words_d;
      overflow       <= ovf_d;
      checksum       <= chk_d;
      sum_valid      <= sv_d;
      last_q         <= last_d;
      rd_cap_q       <= (state_q == ST_READ);
      rd_cnt_q       <= rd_cnt_d;
      len_q          <= len_d;
      acc_q          <= acc_d;
    end
  end

endmodule

// File: tb/tb_mem_stream_loader.sv
// Self-checking bench for mem_stream_loader with a RAM model and write/read scoreboards.
module tb_mem_stream_loader;

  localparam int unsigned ADDR_W = 10;
  localparam int DEPTH = 1024;

  logic              clk;
  logic              reset_n;
  logic [7:0]        in_data;
  logic              in_valid;
  logic              in_last;
  logic              in_ready;
  logic [ADDR_W-1:0] mem_address;
  logic [3:0]        mem_byteenable;
  logic              mem_chipselect;
  logic              mem_write;
  logic [31:0]       mem_writedata;
  logic [31:0]       mem_readdata;
  logic              sum_start;
  logic [ADDR_W:0]   sum_len;
  logic              busy;
  logic              load_done;
  logic [ADDR_W:0]   load_words;
  logic              overflow;
  logic [31:0]       checksum;
  logic              sum_valid;

  mem_stream_loader #(.ADDR_W(ADDR_W), .BASE_ADDR(0)) dut (
    .clk(clk), .reset_n(reset_n),
    .in_data(in_data), .in_valid(in_valid), .in_last(in_last), .in_ready(in_ready),
    .mem_address(mem_address), .mem_byteenable(mem_byteenable),
    .mem_chipselect(mem_chipselect), .mem_write(mem_write),
    .mem_writedata(mem_writedata), .mem_readdata(mem_readdata),
    .sum_start(sum_start), .sum_len(sum_len), .busy(busy),
    .load_done(load_done), .load_words(load_words), .overflow(overflow),
    .checksum(checksum), .sum_valid(sum_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                        input logic [3:0] be);
    merge = old;
    for (int i = 0; i < 4; i++) if (be[i]) merge[8*i +: 8] = nw[8*i +: 8];
  endfunction

  // RAM model: byte-lane writes, registered read data.
  logic [31:0] ram [DEPTH];
  always @(posedge clk) begin
    if (mem_chipselect && mem_write)
      ram[mem_address] <= merge(ram[mem_address], mem_writedata, mem_byteenable);
    if (mem_chipselect && !mem_write)
      mem_readdata <= ram[mem_address];
  end

  typedef struct packed {
    logic [9:0]  addr;
    logic [31:0] data;
    logic [3:0]  be;
  } wr_t;

  wr_t         wr_q[$];
  logic [9:0]  rd_q[$];
  logic [31:0] sum_q[$];
  logic [7:0]  stim_q[$];
  logic [31:0] exp_ram [DEPTH];
  int          exp_lw;
  int          checks = 0;
  int          errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name, input logic [31:0] act);
    checks++;
    errors++;
    $display("FAIL %s: got %h expected nothing", name, act);
  endtask

  // Output monitor: every RAM access and checksum pulse must match a queued expectation.
  task automatic monitor();
    wr_t w;
    forever begin
      @(negedge clk);
      if (mem_chipselect && mem_write) begin
        if (wr_q.size() == 0) fail_now("unexpected_write", 32'(mem_address));
        else begin
          w = wr_q.pop_front();
          chk("wr_addr", 32'(mem_address), 32'(w.addr));
          chk("wr_data", mem_writedata, w.data);
          chk("wr_be", 32'(mem_byteenable), 32'(w.be));
        end
      end
      if (mem_chipselect && !mem_write) begin
        if (rd_q.size() == 0) fail_now("unexpected_read", 32'(mem_address));
        else begin
          chk("rd_addr", 32'(mem_address), 32'(rd_q.pop_front()));
          chk("rd_be", 32'(mem_byteenable), 32'hF);
        end
      end
      if (sum_valid) begin
        if (sum_q.size() == 0) fail_now("unexpected_sum_valid", checksum);
        else chk("checksum", checksum, sum_q.pop_front());
      end
    end
  endtask

  // Present one byte from a negedge and hold it until accepted.
  task automatic send_byte(input logic [7:0] b, input logic last);
    int guard = 0;
    in_data = b; in_valid = 1'b1; in_last = last;
    #1;
    while (!in_ready && guard < 20) begin
      @(negedge clk); #1; guard++;
    end
    if (!in_ready) fail_now("in_ready_timeout", 32'(b));
    @(negedge clk);
    in_valid = 1'b0; in_last = 1'b0;
  endtask

  // Stream stim_q as one load; optionally pulse sum_start alongside byte start_at.
  task automatic do_load(input string tag, input int exp_words, input logic exp_ovf,
                         input logic [3:0] exp_be, input logic [31:0] exp_data,
                         input int start_at);
    int n, nw, t0;
    logic [31:0] word;
    logic [3:0]  be;
    n = stim_q.size(); nw = (n + 3) / 4; t0 = 0;
    word = '0; be = '0;
    for (int i = 0; i < n; i++) begin
      word[8*(i%4) +: 8] = stim_q[i];
      be[i%4] = 1'b1;
      if ((i % 4 == 3) || (i == n - 1)) begin
        if (i / 4 < DEPTH) begin
          wr_q.push_back('{addr: 10'(i/4), data: word, be: be});
          exp_ram[i/4] = merge(exp_ram[i/4], word, be);
        end
        word = '0; be = '0;
      end
    end
    for (int i = 0; i < n; i++) begin
      if (i == start_at) begin sum_start = 1'b1; sum_len = 11'd3; end
      send_byte(stim_q[i], i == n - 1);
      sum_start = 1'b0;
      if (i == 0) t0 = cyc;
    end
    stim_q.delete();
    if (exp_ovf) chk({tag, "_final_cs"}, 32'(mem_chipselect), 0);
    else begin
      chk({tag, "_final_cs"}, 32'(mem_chipselect && mem_write), 1);
      chk({tag, "_final_be"}, 32'(mem_byteenable), 32'(exp_be));
      chk({tag, "_final_data"}, mem_writedata, exp_data);
    end
    @(negedge clk);
    chk({tag, "_load_done"}, 32'(load_done), 1);
    chk({tag, "_done_cycle"}, 32'(cyc - t0), 32'(n + nw - 1));
    chk({tag, "_load_words"}, 32'(load_words), 32'(exp_words));
    chk({tag, "_overflow"}, 32'(overflow), 32'(exp_ovf));
    exp_lw = exp_words;
    @(negedge clk);
    chk({tag, "_done_pulse"}, 32'(load_done), 0);
    chk({tag, "_idle"}, 32'(busy), 0);
  endtask

  // Run one readback and check its timing; with_byte also offers a byte in the start cycle.
  task automatic do_sum(input string tag, input int len, input logic with_byte,
                        input logic use_const, input logic [31:0] exp_const);
    int eff, c0, guard;
    logic [31:0] s;
    eff = (len > DEPTH) ? DEPTH : len;
    s = '0; guard = 0;
    for (int i = 0; i < eff; i++) begin
      rd_q.push_back(10'(i));
      s = s + exp_ram[i];
    end
    sum_q.push_back(s);
    sum_start = 1'b1; sum_len = 11'(len);
    if (with_byte) begin in_valid = 1'b1; in_data = 8'h77; in_last = 1'b0; end
    #1;
    chk({tag, "_start_in_ready"}, 32'(in_ready), 0);
    c0 = cyc;
    @(negedge clk);
    sum_start = 1'b0; in_valid = 1'b0;
    if (eff > 0) begin
      chk({tag, "_first_addr_cs"}, 32'(mem_chipselect && !mem_write), 1);
      chk({tag, "_busy"}, 32'(busy), 1);
    end
    while (!sum_valid && guard < 1100) begin @(negedge clk); guard++; end
    if (!sum_valid) fail_now({tag, "_sum_valid_timeout"}, 32'(guard));
    chk({tag, "_sum_cycle"}, 32'(cyc - c0), (eff == 0) ? 32'd1 : 32'(eff + 2));
    if (use_const) chk({tag, "_checksum_const"}, checksum, exp_const);
    @(negedge clk);
    chk({tag, "_sum_pulse"}, 32'(sum_valid), 0);
    chk({tag, "_checksum_held"}, checksum, s);
    chk({tag, "_idle"}, 32'(busy), 0);
    chk({tag, "_load_words_kept"}, 32'(load_words), 32'(exp_lw));
  endtask

  typedef struct {
    int          n;
    logic [7:0]  b0;
    int          exp_words;
    logic        exp_ovf;
    logic [3:0]  exp_be;
    logic [31:0] exp_data;
  } load_vec_t;

  typedef struct {
    int          len;
    logic        use_const;
    logic [31:0] exp;
  } sum_vec_t;

  load_vec_t lv [6];
  sum_vec_t  sv [5];

  initial begin
    lv[0] = '{8,    8'h01, 2,    1'b0, 4'hF, 32'h08070605};
    lv[1] = '{6,    8'h11, 2,    1'b0, 4'h3, 32'h00001615};
    lv[2] = '{1,    8'hA0, 1,    1'b0, 4'h1, 32'h000000A0};
    lv[3] = '{7,    8'h30, 2,    1'b0, 4'h7, 32'h00363534};
    lv[4] = '{4100, 8'h00, 1024, 1'b1, 4'hF, 32'h0};
    lv[5] = '{4,    8'h40, 1,    1'b0, 4'hF, 32'h43424140};
    sv[0] = '{0,    1'b1, 32'h0};
    sv[1] = '{1,    1'b1, 32'h1};
    sv[2] = '{3,    1'b1, 32'h2};
    sv[3] = '{5,    1'b1, 32'h22201E1E};
    sv[4] = '{2000, 1'b0, 32'h0};
    for (int i = 0; i < DEPTH; i++) exp_ram[i] = '0;
    exp_lw = 0;

    reset_n = 1'b0; in_data = '0; in_valid = 1'b0; in_last = 1'b0;
    sum_start = 1'b0; sum_len = '0;
    fork monitor(); join_none

    repeat (2) @(negedge clk);
    chk("rst_in_ready", 32'(in_ready), 0);
    chk("rst_mem", {22'(0), mem_chipselect, mem_write, mem_byteenable, 4'(mem_address)}, 0);
    chk("rst_flags", {28'(0), busy, load_done, overflow, sum_valid}, 0);
    chk("rst_load_words", 32'(load_words), 0);
    chk("rst_checksum", checksum, 0);
    reset_n = 1'b1;
    @(negedge clk);
    chk("idle_in_ready", 32'(in_ready), 1);

    for (int v = 0; v < 6; v++) begin
      for (int i = 0; i < lv[v].n; i++) stim_q.push_back(8'(lv[v].b0 + 8'(i)));
      do_load($sformatf("load%0d", v), lv[v].exp_words, lv[v].exp_ovf,
              lv[v].exp_be, lv[v].exp_data, -1);
    end

    // RAM words 0..2 = 1, 2, 0xFFFFFFFF for the readback vectors.
    stim_q = '{8'h01, 8'h00, 8'h00, 8'h00, 8'h02, 8'h00, 8'h00, 8'h00,
               8'hFF, 8'hFF, 8'hFF, 8'hFF};
    do_load("preload", 3, 1'b0, 4'hF, 32'hFFFFFFFF, -1);

    for (int v = 0; v < 5; v++)
      do_sum($sformatf("sum%0d", v), sv[v].len, 1'b0, sv[v].use_const, sv[v].exp);

    do_sum("start_vs_byte", 1, 1'b1, 1'b1, 32'h1);

    stim_q = '{8'h51, 8'h52, 8'h53, 8'h54};
    do_load("start_in_pack", 1, 1'b0, 4'hF, 32'h54535251, 2);

    send_byte(8'h61, 1'b0);
    send_byte(8'h62, 1'b0);
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    chk("midrst_in_ready", 32'(in_ready), 0);
    chk("midrst_mem", {22'(0), mem_chipselect, mem_write, mem_byteenable, 4'(mem_address)}, 0);
    chk("midrst_wdata", mem_writedata, 0);
    chk("midrst_flags", {28'(0), busy, load_done, overflow, sum_valid}, 0);
    chk("midrst_load_words", 32'(load_words), 0);
    chk("midrst_checksum", checksum, 0);
    @(negedge clk);
    chk("midrst_ready_back", 32'(in_ready), 1);
    stim_q = '{8'h71, 8'h72, 8'h73, 8'h74};
    do_load("after_rst", 1, 1'b0, 4'hF, 32'h74737271, -1);

    repeat (3) @(negedge clk);
    chk("wr_q_drained", 32'(wr_q.size()), 0);
    chk("rd_q_drained", 32'(rd_q.size()), 0);
    chk("sum_q_drained", 32'(sum_q.size()), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/mem_stream_loader.md
# mem_stream_loader

Upstream master for the 1024×32 single-port on-chip RAM. Accepts a byte stream (valid/ready, with last), packs bytes little-endian into 32-bit words and writes them to consecutive RAM addresses with correct byteenables for a partial final word. Also provides a readback mode that streams a range of words out of the RAM and returns their 32-bit modular sum, so software or a bench can confirm the load. Sits between the byte-stream source (UART/host link) and the RAM's Avalon slave port.

## Interface
Parameters:
- ADDR_W, 10, RAM word-address width; depth = 2^ADDR_W = 1024
- BASE_ADDR, 0, first word address written by every load and read by every readback

Ports:
- clk  in  1  system clock
- reset_n  in  1  synchronous, active-low reset; one clock, synchronous reset
- in_data  in  8  stream byte
- in_valid  in  1  in_data valid
- in_last  in  1  final byte of the load; qualified by in_valid & in_ready
- in_ready  out  1  block accepts byte this cycle
- mem_address  out  ADDR_W  RAM word address
- mem_byteenable  out  4  RAM byte lanes; bit i = bits 8i+7:8i
- mem_chipselect  out  1  RAM access strobe
- mem_write  out  1  RAM write strobe
- mem_writedata  out  32  RAM write data
- mem_readdata  in  32  RAM read data, valid the cycle after address presented
- sum_start  in  1  start readback (pulse)
- sum_len  in  ADDR_W+1  words to read; values > 1024 clamp to 1024
- busy  out  1  state ≠ IDLE
- load_done  out  1  one-cycle pulse at load completion
- load_words  out  ADDR_W+1  words written by current/last load, saturates at 1024
- overflow  out  1  sticky: load exceeded RAM depth; cleared at first byte of next load
- checksum  out  32  sum of last readback, held until next sum_start
- sum_valid  out  1  one-cycle pulse, checksum updated

## Operation
- Reset values: in_ready 0 for the reset cycle, then 1 in IDLE; all mem_* 0; busy, load_done, overflow, sum_valid 0; load_words 0; checksum 0. Reset mid-operation aborts immediately; partially packed bytes are discarded, no write is issued.
- States: IDLE, PACK, WRITE, READ, DRAIN.
- IDLE: in_ready=1. An accepted byte goes to lane 0, load_words and overflow are cleared, address = BASE_ADDR → PACK (or WRITE if in_last). sum_start in IDLE → READ; sum_start wins over a simultaneous in_valid (in_ready=0 that cycle). sum_start outside IDLE is ignored.
- PACK: in_ready=1; the byte count k (0–3) selects the lane. An accepted 4th byte or any accepted in_last byte → WRITE.
- WRITE: one cycle; in_ready=0; chipselect=write=1; byteenable = lanes filled (4'hF full, 4'h1/3/7 partial); unfilled writedata lanes are 0. Address increments after the write; load_words increments. Next state is PACK, or IDLE with load_done pulsed next cycle if the word closed on in_last.
- Overflow: if the write would target the address after BASE_ADDR+1023, the block suppresses it (no chipselect), sets overflow, continues accepting and dropping bytes, and ends at in_last with load_done. Address does not wrap into written data.
- READ: issue addresses BASE_ADDR … BASE_ADDR+L−1, one per cycle, chipselect=1, write=0, byteenable=4'hF. Accumulate mem_readdata mod 2^32 one cycle after each address.
- DRAIN: capture the final word, then update checksum and pulse sum_valid → IDLE. sum_len=0: no reads, checksum=0, sum_valid the cycle after start.

## Timing
- Byte throughput: 4 bytes per 5 cycles with continuous valid; the stall is the WRITE cycle.
- Write issued the cycle after the closing byte is accepted. load_done is one cycle after that write.
- Readback: sum_start sampled in cycle 0; addresses in cycles 1..L; data captured in 2..L+1; sum_valid and the new checksum in cycle L+2.
- All outputs registered; no combinational path from in_valid to in_ready.

## Structure
- Shared package: state enum, RAM_DEPTH=1024, BYTES_PER_WORD=4, byteenable lookup for k filled lanes.
- Single module. An optional sub-module, byte_packer (lane register + count + byteenable), is natural. The FSM, address counter and accumulator stay at top level.

## Test plan
- Bytes 0x01..0x08, last on 0x08 → writes addr0 0x04030201 be F, addr1 0x08070605 be F; load_done; load_words=2.
- 6 bytes 0x11..0x16, last on 0x16 → addr1 write 0x00001615 be 4'h3; load_words=2; overflow=0.
- 4100 bytes, last on final → exactly 1024 writes (addr 0..1023), none after; overflow=1; load_words=1024; load_done after last byte.
- RAM words 1,2,0xFFFFFFFF, sum_start with sum_len=3 → addresses 0,1,2 in cycles 1–3; checksum=0x00000002; sum_valid in cycle 5. sum_len=0 → checksum 0, sum_valid in cycle 1.
- sum_start and in_valid together in IDLE → readback runs, byte not accepted (in_ready=0); sum_start during PACK ignored.
- reset_n low after 2 bytes of a word → no write issued; all outputs return to reset values the next cycle; next load starts at addr 0.
